// File: rtl/branch_aux_if.sv
// Signal bundle between the branch/call decode logic and the branch_aux target generator.
// The master drives PC, displacement, select and strobe; the slave returns the target.
interface branch_aux_if #(
   parameter int WIDTH  = 32,
   parameter int DISP_W = 30
) ();
   logic [WIDTH-1:0]  in_pc;
   logic [DISP_W-1:0] in_disp;
   logic              BAUX;
   logic              sel;
   logic [WIDTH-1:0]  out;
   logic              out_valid;

   modport master (
      output in_pc,
      output in_disp,
      output BAUX,
      output sel,
      input  out,
      input  out_valid
   );

   modport slave (
      input  in_pc,
      input  in_disp,
      input  BAUX,
      input  sel,
      output out,
      output out_valid
   );
endinterface

// File: rtl/branch_aux.sv
// SPARC branch/call target generator: pc + 4*sext(disp30) for CALL, pc + 4*sext(disp22) for Bicc.
// The target is captured on a BAUX strobe and held for the PC/nPC update logic.
module branch_aux #(
   parameter int WIDTH     = 32,
   parameter int DISP_W    = 30,
   parameter int BR_DISP_W = 22
) (
   input  logic         clk,
   input  logic         reset,
   branch_aux_if.slave  bus
);

   // Sign-extend the CALL displacement (full field) to WIDTH bits.
   function automatic logic signed [WIDTH-1:0] sext_call(input logic [DISP_W-1:0] d);
      return {{(WIDTH-DISP_W){d[DISP_W-1]}}, d};
   endfunction

   // Sign-extend the Bicc displacement; bits above BR_DISP_W are ignored.
   function automatic logic signed [WIDTH-1:0] sext_br(input logic [DISP_W-1:0] d);
      return {{(WIDTH-BR_DISP_W){d[BR_DISP_W-1]}}, d[BR_DISP_W-1:0]};
   endfunction

   // Word displacement to byte offset and modulo-2^WIDTH add; carry-out is dropped.
   function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0]        pc,
                                                input logic signed [WIDTH-1:0] woff);
      logic signed [WIDTH-1:0] boff;
      boff = woff <<< 2;
      return pc + WIDTH'(unsigned'(boff));
   endfunction

   logic signed [WIDTH-1:0] woff_p0;
   logic [WIDTH-1:0]        tgt_p0;
   logic [WIDTH-1:0]        out_p1;
   logic                    vld_p1;

   // Stage 0: combinational target from the current instruction fields
   always_comb begin
      woff_p0 = sext_br(bus.in_disp);
      if (bus.sel == 1'b1) begin
         woff_p0 = sext_call(bus.in_disp);
      end
      tgt_p0 = wrap_add(bus.in_pc, woff_p0);
   end

   // Stage 1: capture on BAUX; reset clears the target too so PC logic never sees stale data
   always_ff @(posedge clk) begin
      if (reset) begin
         out_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= bus.BAUX;
         if (bus.BAUX) begin
            out_p1 <= tgt_p0;
         end
      end
   end

   assign bus.out       = out_p1;
   assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_branch_aux.sv
// Self-checking bench for branch_aux: directed vector table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_branch_aux;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   branch_aux_if #(.WIDTH(32), .DISP_W(30)) bus ();

   branch_aux #(.WIDTH(32), .DISP_W(30), .BR_DISP_W(22)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [29:0] disp;
      logic        sel;
      logic [31:0] exp_out;
      string       name;
   } vec_t;

   vec_t vecs[6];

   // Reference: interpret the displacement as a signed integer and do plain integer math.
   function automatic logic [31:0] model(input logic [31:0] pc, input logic [29:0] disp,
                                         input logic s);
      longint d;
      longint sum;
      if (s)
         d = disp[29] ? longint'(disp) - (longint'(1) << 30) : longint'(disp);
      else
         d = disp[21] ? longint'(disp[21:0]) - (longint'(1) << 22) : longint'(disp[21:0]);
      sum = longint'(pc) + 4 * d;
      return 32'(sum & 64'hFFFF_FFFF);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst_v, input logic [31:0] pc, input logic [29:0] disp,
                        input logic s, input logic baux);
      @(negedge clk);
      reset       = rst_v;
      bus.in_pc   = pc;
      bus.in_disp = disp;
      bus.sel     = s;
      bus.BAUX    = baux;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] held;
   logic [31:0] exp_out;
   logic        exp_vld;
   logic [31:0] r0, r1;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset       = 1'b1;
      bus.in_pc   = 32'h0;
      bus.in_disp = 30'h0;
      bus.sel     = 1'b0;
      bus.BAUX    = 1'b0;

      vecs[0] = '{32'h5,        30'h3FFF_FFFF, 1'b1, 32'h0000_0001, "call_minus1"};
      vecs[1] = '{32'h5,        30'h3FFF_FFFF, 1'b0, 32'h0000_0001, "bicc_minus1"};
      vecs[2] = '{32'h100,      30'h0020_0000, 1'b0, 32'hFF80_0100, "bicc_neg_max"};
      vecs[3] = '{32'h100,      30'h0020_0000, 1'b1, 32'h0080_0100, "call_pos"};
      vecs[4] = '{32'hFFFF_FFFC, 30'h1,        1'b1, 32'h0000_0000, "wrap"};
      vecs[5] = '{32'h1000,     30'h3FC0_0010, 1'b0, 32'h0000_1040, "bicc_ignore_hi"};

      // Reset with BAUX asserted: reset wins
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h1234, 30'h55, 1'b1, 1'b1);
         check("reset_out", bus.out, 32'h0);
         check("reset_vld", {31'b0, bus.out_valid}, 32'h0);
      end

      // Directed table: capture pulse then hold
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, vecs[i].pc, vecs[i].disp, vecs[i].sel, 1'b1);
         check({vecs[i].name, "_out"}, bus.out, vecs[i].exp_out);
         check({vecs[i].name, "_vld"}, {31'b0, bus.out_valid}, 32'h1);
         drive(1'b0, vecs[i].pc + 32'h40, ~vecs[i].disp, ~vecs[i].sel, 1'b0);
         check({vecs[i].name, "_hold"}, bus.out, vecs[i].exp_out);
         check({vecs[i].name, "_vld0"}, {31'b0, bus.out_valid}, 32'h0);
      end

      // Hold under random input churn, including unknown sel
      held = bus.out;
      for (int i = 0; i < 10; i++) begin
         r0 = $urandom;
         r1 = $urandom;
         drive(1'b0, r0, r1[29:0], (i % 3 == 0) ? 1'bx : r1[31], 1'b0);
         check("churn_hold", bus.out, held);
         check("churn_vld", {31'b0, bus.out_valid}, 32'h0);
      end

      // BAUX held high: recapture each cycle with one-cycle latency
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'(4 * i), 30'h1, 1'b1, 1'b1);
         check("stream_out", bus.out, 32'(4 * i + 4));
         check("stream_vld", {31'b0, bus.out_valid}, 32'h1);
      end

      // Reset mid-stream clears a captured target
      drive(1'b1, 32'h800, 30'h2, 1'b1, 1'b1);
      check("mid_reset_out", bus.out, 32'h0);
      check("mid_reset_vld", {31'b0, bus.out_valid}, 32'h0);

      // Randomized traffic against the reference model
      exp_out = 32'h0;
      exp_vld = 1'b0;
      for (int i = 0; i < 300; i++) begin
         logic b, s, rs;
         r0 = $urandom;
         r1 = $urandom;
         b  = r1[30];
         s  = r1[31];
         rs = ($urandom_range(0, 39) == 0);
         if (rs) begin
            exp_out = 32'h0;
            exp_vld = 1'b0;
         end else if (b) begin
            exp_out = model(r0, r1[29:0], s);
            exp_vld = 1'b1;
         end else begin
            exp_vld = 1'b0;
         end
         drive(rs, r0, r1[29:0], s, b);
         check("rand_out", bus.out, exp_out);
         check("rand_vld", {31'b0, bus.out_valid}, {31'b0, exp_vld});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
